// File: rtl/regbank_arb_pkg.sv
// rtl/regbank_arb_pkg.sv - shared types and helpers for the register bank write arbiter
package regbank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

  // Pointer width for an n-entry round-robin ring (at least one bit)
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - rotating priority picker: first set request at or after ptr
module rr_prio_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [PW-1:0] win_idx_o,
  output logic          any_o
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest request to ptr wins last
  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        win_o      = '0;
        win_o[idx] = 1'b1;
        win_idx_o  = idx;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// rtl/regbank_wr_arbiter.sv - round-robin write arbiter for a shared register bank; optional burst lock via ARB_LOCK_EN
module regbank_wr_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
`ifdef ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 4
`endif
) (
  input  logic                   CLK,
  input  logic                   CLRN,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   clr_req,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic                   reg_en,
  output logic [WIDTH-1:0]       reg_d,
  output logic                   reg_nrst,
  output logic                   busy
);

  localparam int PW = ptr_w(N_REQ);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             reg_en_q, reg_en_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             reg_nrst_q, reg_nrst_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

  // A clear request is serviced at the very next edge, so it never needs storage
  logic             clr_pend;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick_win;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [PW-1:0] last_idx_q, last_idx_d;
  logic          regrant;
`endif

  assign clr_pend = clr_req;

  // The requester granted last cycle still shows req on this edge; hide it once
  assign elig = req & ((state_q == GRANT) ? ~gnt_q : {N_REQ{1'b1}});

`ifdef ARB_LOCK_EN
  assign regrant = (state_q == GRANT) && (|(gnt_q & lock & req)) &&
                   (lock_cnt_q < CW'(LOCK_MAX));
`endif

  rr_prio_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req_i     (elig),
    .ptr_i     (rr_ptr_q),
    .win_o     (pick_win),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Next-state and registered-output decode: clear beats lock regrant beats round-robin
  always_comb begin
    state_d    = IDLE;
    gnt_d      = '0;
    reg_en_d   = 1'b0;
    reg_d_d    = reg_d_q;
    reg_nrst_d = 1'b1;
    rr_ptr_d   = rr_ptr_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d = '0;
    last_idx_d = last_idx_q;
`endif
    if (clr_pend) begin
      state_d    = CLEAR;
      reg_nrst_d = 1'b0;
    end
`ifdef ARB_LOCK_EN
    else if (regrant) begin
      state_d    = GRANT;
      gnt_d      = gnt_q;
      reg_en_d   = 1'b1;
      reg_d_d    = wdata[int'(last_idx_q)*WIDTH +: WIDTH];
      lock_cnt_d = lock_cnt_q + CW'(1);
    end
`endif
    else if (pick_any) begin
      state_d  = GRANT;
      gnt_d    = pick_win;
      reg_en_d = 1'b1;
      reg_d_d  = wdata[int'(pick_idx)*WIDTH +: WIDTH];
      rr_ptr_d = PW'((int'(pick_idx) + 1) % N_REQ);
`ifdef ARB_LOCK_EN
      lock_cnt_d = CW'(1);
      last_idx_d = pick_idx;
`endif
    end
  end

  // State and output registers; reset returns the bank controls to inactive at once
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      reg_en_q   <= 1'b0;
      reg_d_q    <= '0;
      reg_nrst_q <= 1'b1;
      rr_ptr_q   <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= '0;
      last_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      reg_en_q   <= reg_en_d;
      reg_d_q    <= reg_d_d;
      reg_nrst_q <= reg_nrst_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
      last_idx_q <= last_idx_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign reg_en   = reg_en_q;
  assign reg_d    = reg_d_q;
  assign reg_nrst = reg_nrst_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// tb/tb_regbank_wr_arbiter.sv - self-checking bench for regbank_wr_arbiter
module tb_regbank_wr_arbiter;

  logic        CLK;
  logic        CLRN;
  logic [3:0]  req_s;
  logic [31:0] wdata_s;
  logic        clr_s;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock_s;
`endif
  logic [3:0]  gnt;
  logic        reg_en;
  logic [7:0]  reg_d;
  logic        reg_nrst;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] bank_q = 8'h00;
  logic [7:0] e_bank = 8'h00;
  logic       p_en   = 1'b0;
  logic       p_nrst = 1'b1;
  logic [7:0] p_d    = 8'h00;

  int m_ptr  = 0;
  int m_last = -1;

  regbank_wr_arbiter dut (
    .CLK      (CLK),
    .CLRN     (CLRN),
    .req      (req_s),
    .wdata    (wdata_s),
    .clr_req  (clr_s),
`ifdef ARB_LOCK_EN
    .lock     (lock_s),
`endif
    .gnt      (gnt),
    .reg_en   (reg_en),
    .reg_d    (reg_d),
    .reg_nrst (reg_nrst),
    .busy     (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared register bank built from d_en_ff cells
  always @(posedge CLK) begin
    if (!reg_nrst) bank_q <= 8'h00;
    else if (reg_en) bank_q <= reg_d;
  end

  typedef struct {
    logic [3:0] req;
    logic       clr;
    logic [3:0] gnt;
    logic       en;
    logic [7:0] d;
    logic       nrst;
    logic       busy;
  } vec_t;

  vec_t vecs [0:16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic c, input logic [3:0] egnt,
                       input logic een, input logic [7:0] ed, input logic enrst,
                       input logic ebusy);
    req_s = r;
    clr_s = c;
    if (!p_nrst) e_bank = 8'h00;
    else if (p_en) e_bank = p_d;
    @(posedge CLK);
    #1;
    clr_s = 1'b0;
    check("gnt", 32'(gnt), 32'(egnt));
    check("reg_en", 32'(reg_en), 32'(een));
    check("reg_nrst", 32'(reg_nrst), 32'(enrst));
    check("busy", 32'(busy), 32'(ebusy));
    if (een) check("reg_d", 32'(reg_d), 32'(ed));
    check("bank_q", 32'(bank_q), 32'(e_bank));
    p_en   = een;
    p_d    = ed;
    p_nrst = enrst;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_en"}, 32'(reg_en), 32'h0);
    check({tag, "_d"}, 32'(reg_d), 32'h0);
    check({tag, "_nrst"}, 32'(reg_nrst), 32'h1);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    CLRN   = 1'b0;
    req_s  = 4'b0000;
    clr_s  = 1'b0;
    p_en   = 1'b0;
    p_nrst = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_idle_outputs("reset");
    CLRN   = 1'b1;
    m_ptr  = 0;
    m_last = -1;
  endtask

  // Reference: clear wins; otherwise first requester at or after the pointer,
  // skipping whoever was granted on the previous cycle
  task automatic model_cycle();
    logic [3:0] eg;
    logic       een;
    logic       enr;
    logic       eb;
    logic [7:0] ed;
    int         w;
    int         i;
    eg  = 4'b0000;
    een = 1'b0;
    enr = 1'b1;
    eb  = 1'b0;
    ed  = 8'h00;
    w   = -1;
    if (clr_s) begin
      enr    = 1'b0;
      eb     = 1'b1;
      m_last = -1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (w < 0 && req_s[i] && i != m_last) w = i;
      end
      if (w >= 0) begin
        eg[w] = 1'b1;
        een   = 1'b1;
        eb    = 1'b1;
        ed    = wdata_s[w*8 +: 8];
        m_ptr = (w + 1) % 4;
      end
      m_last = w;
    end
    cycle(req_s, clr_s, eg, een, ed, enr, eb);
  endtask

  initial begin
    CLRN    = 1'b0;
    req_s   = 4'b0000;
    clr_s   = 1'b0;
    wdata_s = 32'h3C5A96A5;
`ifdef ARB_LOCK_EN
    lock_s  = 4'b0000;
`endif

    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 1'b1};
    vecs[1]  = '{4'b1110, 1'b0, 4'b0010, 1'b1, 8'h96, 1'b1, 1'b1};
    vecs[2]  = '{4'b1100, 1'b0, 4'b0100, 1'b1, 8'h5A, 1'b1, 1'b1};
    vecs[3]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 8'h3C, 1'b1, 1'b1};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 1'b1};
    vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'h96, 1'b1, 1'b1};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'h5A, 1'b1, 1'b1};
    vecs[11] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'h5A, 1'b1, 1'b1};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[14] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'h3C, 1'b1, 1'b1};
    vecs[15] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 1'b1};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};

    do_reset();

    // Fairness, single write, clear priority, mask, pointer wrap
    for (int v = 0; v <= 16; v++)
      cycle(vecs[v].req, vecs[v].clr, vecs[v].gnt, vecs[v].en, vecs[v].d,
            vecs[v].nrst, vecs[v].busy);

    // Reset in the middle of a grant cycle, then the pointer restarts at 0
    cycle(4'b0010, 1'b0, 4'b0010, 1'b1, 8'h96, 1'b1, 1'b1);
    #3;
    CLRN   = 1'b0;
    p_en   = 1'b0;
    p_nrst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(posedge CLK);
    #1;
    check_idle_outputs("inreset");
    CLRN = 1'b1;
    cycle(4'b0100, 1'b0, 4'b0100, 1'b1, 8'h5A, 1'b1, 1'b1);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0);

`ifdef ARB_LOCK_EN
    // Locked requester 0 holds the bank for four grants, then rotation is forced
    do_reset();
    lock_s = 4'b0001;
    for (int n = 0; n < 4; n++)
      cycle(4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 1'b1);
    cycle(4'b0011, 1'b0, 4'b0010, 1'b1, 8'h96, 1'b1, 1'b1);
    cycle(4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 1'b1);
    lock_s = 4'b0000;
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Random client traffic against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      clr_s = ($urandom_range(0, 15) == 0);
      model_cycle();
      for (int i = 0; i < 4; i++) begin
        if (req_s[i]) begin
          if (gnt[i] && $urandom_range(0, 3) != 0) req_s[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_s[i] = 1'b1;
          wdata_s[i*8 +: 8] = 8'($urandom);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
